// File: rtl/sfq_sched_pkg.sv
// Shared types and defaults for the SFQ XOR gate scheduler.
// Holds the FSM state enum, id/counter width helpers and timing defaults.
package sfq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    SETUP = 3'd2,
    CLOCK = 3'd3,
    WAIT  = 3'd4,
    HOLD  = 3'd5,
    RESP  = 3'd6
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_PULSE_W   = 1;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_RESP_WIN  = 4;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The shared counter only holds (duration - 1).
  function automatic int cnt_w(
    input int pw,
    input int su,
    input int rw,
    input int hc
  );
    int m;
    m = pw;
    if (su > m) m = su;
    if (rw > m) m = rw;
    if (hc > m) m = hc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal pointer.
// Ports: req in, advance in, one-hot grant out, encoded id out.
module rr_arbiter
  import sfq_sched_pkg::*;
#(
  parameter  int N  = DEF_N_REQ,
  localparam int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] id
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] sel;
  logic          found;
  int            idx;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        id         = sel;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (id == IW'(N - 1)) ? '0 : id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xor_gate_sched.sv
// Shares one clocked SFQ XOR gate among N_REQ requesters.
// Ports: req_valid/a/b in, req_ready out, resp_* out, g_* gate pins.
module xor_gate_sched
  import sfq_sched_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int PULSE_W   = DEF_PULSE_W,
  parameter  int SETUP_CYC = DEF_SETUP_CYC,
  parameter  int RESP_WIN  = DEF_RESP_WIN,
  parameter  int HOLD_CYC  = DEF_HOLD_CYC,
  localparam int IW        = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic             resp_valid,
  output logic [IW-1:0]    resp_id,
  output logic             resp_data,
  output logic             mismatch,
  output logic             err_spurious,
  output logic             busy,
  output logic             g_dina,
  output logic             g_dinb,
  output logic             g_clk,
  input  logic             g_dout
);

  localparam int CW = cnt_w(PULSE_W, SETUP_CYC,
                            RESP_WIN, HOLD_CYC);

  localparam logic [CW-1:0] LD_PW = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LD_SU = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_RW = CW'(RESP_WIN - 1);
  localparam logic [CW-1:0] LD_HC =
    CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_q, a_d;
  logic          b_q, b_d;
  logic [IW-1:0] id_q, id_d;
  logic          flag_q, flag_d;

  logic          g_dina_q, g_dina_d;
  logic          g_dinb_q, g_dinb_d;
  logic          g_clk_q, g_clk_d;
  logic          busy_q, busy_d;
  logic          rv_q, rv_d;
  logic [IW-1:0] rid_q, rid_d;
  logic          rdata_q, rdata_d;
  logic          mism_q, mism_d;
  logic          err_q, err_d;

  logic             idle;
  logic             last;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gnt_id;

  assign idle    = (state_q == IDLE);
  assign last    = (cnt_q == '0);
  assign arb_req = req_valid & {N_REQ{idle}};

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (idle),
    .grant   (grant),
    .id      (gnt_id)
  );

  // Grant is combinational; forced low while reset is held.
  assign req_ready = grant & {N_REQ{rst_n}};

  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - 1'b1;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d = DRIVE;
          cnt_d   = LD_PW;
          a_d     = |(req_a & grant);
          b_d     = |(req_b & grant);
          id_d    = gnt_id;
          flag_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (last) begin
          state_d = SETUP;
          cnt_d   = LD_SU;
        end
      end
      SETUP: begin
        if (last) begin
          state_d = CLOCK;
          cnt_d   = LD_PW;
        end
      end
      CLOCK: begin
        if (last) begin
          state_d = WAIT;
          cnt_d   = LD_RW;
        end
      end
      WAIT: begin
        if (g_dout) flag_d = 1'b1;
        if (last) begin
          if (HOLD_CYC == 0) begin
            state_d = RESP;
          end else begin
            state_d = HOLD;
            cnt_d   = LD_HC;
          end
        end
      end
      HOLD: begin
        if (last) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state.
  always_comb begin
    g_dina_d = (state_d == DRIVE) & a_d;
    g_dinb_d = (state_d == DRIVE) & b_d;
    g_clk_d  = (state_d == CLOCK);
    busy_d   = (state_d != IDLE);
    rv_d     = (state_d == RESP);
    rid_d    = rv_d ? id_d : '0;
    rdata_d  = rv_d & flag_d;
    mism_d   = rv_d & (flag_d ^ a_d ^ b_d);
    err_d    = g_dout & (state_q != WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      id_q     <= '0;
      flag_q   <= 1'b0;
      g_dina_q <= 1'b0;
      g_dinb_q <= 1'b0;
      g_clk_q  <= 1'b0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= 1'b0;
      mism_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      flag_q   <= flag_d;
      g_dina_q <= g_dina_d;
      g_dinb_q <= g_dinb_d;
      g_clk_q  <= g_clk_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      mism_q   <= mism_d;
      err_q    <= err_d;
    end
  end

  assign g_dina       = g_dina_q;
  assign g_dinb       = g_dinb_q;
  assign g_clk        = g_clk_q;
  assign busy         = busy_q;
  assign resp_valid   = rv_q;
  assign resp_id      = rid_q;
  assign resp_data    = rdata_q;
  assign mismatch     = mism_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_xor_gate_sched.sv
// Random bench for xor_gate_sched against a timing-offset model.
// Model tracks cycles since grant and derives every pin from that.
module tb_xor_gate_sched;

  localparam int N   = 4;
  localparam int PW  = 1;
  localparam int SU  = 2;
  localparam int RW  = 4;
  localparam int HC  = 1;
  localparam int CLO = 1 + PW + SU;
  localparam int CHI = 2 * PW + SU;
  localparam int WLO = 2 * PW + SU + 1;
  localparam int WHI = 2 * PW + SU + RW;
  localparam int RT  = WHI + HC + 1;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [N-1:0] req_ready;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic         resp_data;
  logic         mismatch;
  logic         err_spurious;
  logic         busy;
  logic         g_dina;
  logic         g_dinb;
  logic         g_clk;
  logic         g_dout;

  xor_gate_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .mismatch     (mismatch),
    .err_spurious (err_spurious),
    .busy         (busy),
    .g_dina       (g_dina),
    .g_dinb       (g_dinb),
    .g_clk        (g_clk),
    .g_dout       (g_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic expect_eq(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  // Model: ph = -1 idle, else cycles since grant.
  int       ph;
  int       ptr;
  bit       ma;
  bit       mb;
  int       mid;
  bit       mflag;
  bit       err_exp;
  int       pulse_at;
  int       granted;
  int       g;
  bit       in_win;
  logic [N-1:0] eg;

  task automatic check_reset_outs(input string tag);
    expect_eq({tag, ".req_ready"}, req_ready, 0);
    expect_eq({tag, ".busy"}, busy, 0);
    expect_eq({tag, ".g_dina"}, g_dina, 0);
    expect_eq({tag, ".g_dinb"}, g_dinb, 0);
    expect_eq({tag, ".g_clk"}, g_clk, 0);
    expect_eq({tag, ".resp_valid"}, resp_valid, 0);
    expect_eq({tag, ".resp_data"}, resp_data, 0);
    expect_eq({tag, ".mismatch"}, mismatch, 0);
    expect_eq({tag, ".err"}, err_spurious, 0);
  endtask

  task automatic model_reset();
    ph      = -1;
    ptr     = 0;
    mflag   = 1'b0;
    err_exp = 1'b0;
    granted = -1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    g_dout    = 1'b0;
    ma        = 1'b0;
    mb        = 1'b0;
    mid       = 0;
    pulse_at  = 0;
    model_reset();
    // Requester 3 waits through reset; granted first from pointer 0.
    req_valid[3] = 1'b1;
    req_a[3]     = 1'b1;
    #12;
    check_reset_outs("init");
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      // Requester agent
      if (granted >= 0) begin
        req_valid[granted] = ($urandom_range(0, 3) == 0);
        req_a[granted]     = $urandom_range(0, 1);
        req_b[granted]     = $urandom_range(0, 1);
        granted            = -1;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i]     = $urandom_range(0, 1);
          req_b[i]     = $urandom_range(0, 1);
        end else if (req_valid[i] &&
                     $urandom_range(0, 60) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      // Gate: correct pulse once in window, plus rare noise.
      in_win = (ph >= WLO) && (ph <= WHI);
      g_dout = (in_win && (ma ^ mb) && ph == pulse_at) ||
               ($urandom_range(0, 24) == 0);
      #1;

      eg = '0;
      g  = -1;
      if (ph < 0) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (g < 0 && req_valid[j]) g = j;
        end
        if (g >= 0) eg[g] = 1'b1;
      end

      expect_eq("req_ready", req_ready, eg);
      expect_eq("busy", busy, ph >= 0);
      expect_eq("g_dina", g_dina,
                (ph >= 1) && (ph <= PW) && ma);
      expect_eq("g_dinb", g_dinb,
                (ph >= 1) && (ph <= PW) && mb);
      expect_eq("g_clk", g_clk,
                (ph >= CLO) && (ph <= CHI));
      expect_eq("resp_valid", resp_valid, ph == RT);
      if (ph == RT) begin
        expect_eq("resp_id", resp_id, mid);
        expect_eq("resp_data", resp_data, mflag);
        expect_eq("mismatch", mismatch,
                  mflag ^ (ma ^ mb));
      end
      expect_eq("err_spurious", err_spurious, err_exp);

      err_exp = g_dout && !in_win;
      if (in_win && g_dout) mflag = 1'b1;
      if (ph < 0) begin
        if (g >= 0) begin
          ma       = req_a[g];
          mb       = req_b[g];
          mid      = g;
          ptr      = (g + 1) % N;
          mflag    = 1'b0;
          ph       = 1;
          pulse_at = $urandom_range(WLO, WHI);
          granted  = g;
        end
      end else if (ph == RT) begin
        ph = -1;
      end else begin
        ph++;
      end

      // Occasional asynchronous reset mid-cycle.
      if ($urandom_range(0, 150) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check_reset_outs("arst");
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_gate_sched.md
Name: xor_gate_sched

Overview:
- Scheduler that shares one clocked SFQ XOR gate cell among N_REQ requesters.
- Grants one operand pair at a time using round-robin arbitration.
- Sequences the gate cycle: operand pulses on dina/dinb, a setup gap, the gate clock pulse, a fixed response window on dout, then a hold gap.
- Returns the sampled result, tagged with the requester id. Sits between requester logic and the gate's dina/dinb/clk/dout pins, and enforces the gate's setup/hold spacing in system-clock cycles.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- PULSE_W, 1, width in cycles of every pulse driven to the gate (≥1).
- SETUP_CYC, 2, cycles from end of operand pulse to start of gate clock pulse (≥1).
- RESP_WIN, 4, fixed cycles dout is sampled after the gate clock pulse (≥1).
- HOLD_CYC, 1, quiet cycles after the window before the next grant (≥0).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request; held until its req_ready bit is seen.
- req_a  in  N_REQ  operand A per requester.
- req_b  in  N_REQ  operand B per requester.
- req_ready  out  N_REQ  one-hot grant; a/b are sampled in this cycle.
- resp_valid  out  1  result strobe, 1 cycle, no backpressure.
- resp_id  out  $clog2(N_REQ)  requester the result belongs to.
- resp_data  out  1  1 if a dout pulse was seen in the window.
- mismatch  out  1  with resp_valid: resp_data != a^b.
- err_spurious  out  1  1-cycle flag: g_dout high outside WAIT.
- busy  out  1  high in every state except IDLE.
- g_dina  out  1  operand-A pulse to the gate.
- g_dinb  out  1  operand-B pulse to the gate.
- g_clk  out  1  gate clock pulse.
- g_dout  in  1  gate output pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 immediately; the FSM goes to IDLE; the round-robin pointer goes to 0.
  - An operation in flight is dropped with no response.
  - Requesters must keep req_valid asserted; they are re-arbitrated after release.
- FSM sequence: IDLE → DRIVE (PULSE_W) → SETUP (SETUP_CYC) → CLOCK (PULSE_W) → WAIT (RESP_WIN) → HOLD (HOLD_CYC, skipped if 0) → RESP (1) → IDLE.
- IDLE:
  - req_ready is driven combinationally to the first valid requester at or after the pointer, wrapping modulo N_REQ.
  - In that cycle, a/b are latched, the id is latched, the pointer moves to grant+1 mod N_REQ, and the FSM goes to DRIVE.
  - With no valid requests, the FSM stays in IDLE.
- DRIVE: g_dina = latched a and g_dinb = latched b, both registered. An operand of 0 gives no pulse.
- CLOCK: g_clk = 1, registered.
- WAIT: any cycle with g_dout = 1 sets the result flag. The window length is fixed and does not end early.
- RESP:
  - resp_valid = 1, with resp_id, resp_data = flag, mismatch = flag ^ (a^b).
  - The flag clears on entry to DRIVE.
- Latency with defaults: grant at T, g_dina/g_dinb at T+1, g_clk at T+4, WAIT T+5..T+8, HOLD T+9, resp_valid at T+10, next grant at T+11 at the earliest.
  - General formula: resp at T + 2·PULSE_W + SETUP_CYC + RESP_WIN + HOLD_CYC + 1.
- err_spurious:
  - Registered, one cycle after any g_dout = 1 sampled in IDLE, DRIVE, SETUP, CLOCK, HOLD or RESP.
  - It does not alter the result flag or the FSM.
- Stability rules:
  - req_valid dropped before its grant: ignored, no error.
  - req_a/req_b changing after the grant: no effect.
  - A single requester re-requesting immediately is granted again at T+11 if no other requester is pending.

Decomposition:
- Package sfq_sched_pkg holds:
  - the state enum (IDLE, DRIVE, SETUP, CLOCK, WAIT, HOLD, RESP);
  - the ID width function;
  - the default timing constants.
- Sub-module rr_arbiter (N parameter) holds:
  - the req vector, pointer and advance input;
  - the one-hot grant and encoded id outputs.
- The top level holds the FSM, one shared down-counter for all timed states, the operand/id/flag registers and the error logic.

Test Plan:
- Requester 1, a=1, b=0, gate model returns g_dout at T+6 → g_dina=1 only at T+1, g_dinb stays 0, g_clk=1 only at T+4, resp_valid at T+10 with id=1, data=1, mismatch=0.
- Requester 2, a=1, b=1, gate silent → both pulses at T+1, resp at T+10 with data=0, mismatch=0.
- All four requesting at T with pointer 0 → grants 0, 1, 2, 3 at T, T+11, T+22, T+33; four responses with ids in order; busy low only between bursts.
- Faulty gate: a=0, b=0, g_dout pulsed at T+7 → resp_data=1, mismatch=1 at T+10.
- g_dout pulse while idle, and at T+4 during CLOCK → err_spurious one cycle later each time; a resp at T+10 reports data=0.
- rst_n low at T+3 (SETUP) → outputs 0 in the same cycle, no resp; after release, a still-valid requester 3 is granted from pointer 0 and the normal sequence follows.
